// File: rtl/gan_result_streamer.sv
// Captures one GAN frame (generator pixels plus discriminator score), classifies the score
// and streams the ten words to the host over a valid/ready interface.
//
// state     | meaning
// IDLE      | waiting for the generator to finish a frame
// WAIT_DISC | pixels captured, waiting for the discriminator score
// STREAM    | presenting buffered words idx 0..N_PIX, one per accepted beat
// DONE      | one idle-output cycle after the score word, then back to IDLE
module gan_result_streamer #(
  parameter int WIDTH  = 32,
  parameter int N_PIX  = 9,
  parameter int THRESH = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gen_finish,
  input  logic                   disc_finish,
  input  logic [N_PIX*WIDTH-1:0] pixels,
  input  logic [WIDTH-1:0]       score,
  output logic [WIDTH-1:0]       m_data,
  output logic [3:0]             m_idx,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   is_real,
  output logic                   class_valid,
  output logic                   busy,
  output logic                   overrun
);

  typedef enum logic [1:0] {IDLE, WAIT_DISC, STREAM, DONE} state_t;

  localparam logic signed [WIDTH-1:0] THRESH_W = WIDTH'(THRESH);
  localparam logic [3:0]              LAST_IDX = 4'(N_PIX);

  state_t           state, state_nxt;
  logic             gen_q, disc_q;
  logic             gen_rise, disc_rise;
  logic             cap_pix, cap_score, beat;
  logic [3:0]       idx;
  logic [WIDTH-1:0] word_buf [N_PIX+1];

  assign gen_rise  = gen_finish & ~gen_q;
  assign disc_rise = disc_finish & ~disc_q;
  assign beat      = (state == STREAM) & m_ready;

  assign m_valid = (state == STREAM);
  assign m_last  = m_valid & (idx == LAST_IDX);
  assign busy    = (state != IDLE);
  assign m_idx   = idx;
  assign m_data  = word_buf[idx];

  always_comb begin
    state_nxt = state;
    cap_pix   = 1'b0;
    cap_score = 1'b0;
    case (state)
      IDLE: begin
        if (gen_rise) begin
          cap_pix = 1'b1;
          if (disc_rise) begin
            cap_score = 1'b1;
            state_nxt = STREAM;
          end else begin
            state_nxt = WAIT_DISC;
          end
        end
      end
      WAIT_DISC: begin
        if (disc_rise) begin
          cap_score = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (beat && (idx == LAST_IDX)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gen_q       <= 1'b0;
      disc_q      <= 1'b0;
      idx         <= '0;
      is_real     <= 1'b0;
      class_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state  <= state_nxt;
      gen_q  <= gen_finish;
      disc_q <= disc_finish;
      if (gen_rise && (state != IDLE)) overrun <= 1'b1;
      // Score capture wins over the pixel-capture clear when both rise together.
      if (cap_score) begin
        class_valid <= 1'b1;
        is_real     <= ($signed(score) >= THRESH_W);
      end else if (cap_pix) begin
        class_valid <= 1'b0;
      end
      if (cap_score) begin
        idx <= '0;
      end else if (beat) begin
        idx <= (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= N_PIX; k++) word_buf[k] <= '0;
    end else begin
      if (cap_pix) begin
        for (int k = 0; k < N_PIX; k++) word_buf[k] <= pixels[k*WIDTH +: WIDTH];
      end
      if (cap_score) word_buf[N_PIX] <= score;
    end
  end

endmodule

// File: doc/gan_result_streamer.md
Name: gan_result_streamer

Overview:
- Sits directly downstream of the GAN top level (generator + discriminator).
- Captures the nine generator pixels when the generator finishes, and the discriminator score when the discriminator finishes.
- Classifies the score against a signed threshold.
- Serialises the ten captured words over a valid/ready stream to the host-side consumer.

Parameters:
- WIDTH, 32: bit width of each pixel and of the discriminator score (signed fixed-point, same format as the GAN datapath).
- N_PIX, 9: number of generator pixels per frame (3x3).
- THRESH, 0: signed score threshold; score >= THRESH classifies the frame as real.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- gen_finish  input  1  level from GAN counter; high once generator outputs are valid.
- disc_finish  input  1  level from GAN counter; high once discriminator output is valid.
- pixels  input  N_PIX*WIDTH  packed signed pixels; word k at bits [k*WIDTH +: WIDTH]; k=0 is pixel 1x1, k=8 is pixel 3x3.
- score  input  WIDTH  signed discriminator output.
- m_data  output  WIDTH  stream data word.
- m_idx  output  4  index of current word: 0..N_PIX-1 are pixels, N_PIX is the score.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from consumer.
- m_last  output  1  high with the score word (idx N_PIX).
- is_real  output  1  registered classification, valid when class_valid=1.
- class_valid  output  1  high from score capture until the next frame's pixel capture.
- busy  output  1  high in any state other than IDLE.
- overrun  output  1  sticky; set when a gen_finish rising edge arrives while not in IDLE.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state IDLE, capture buffers 0, edge-detect registers 0. Assertion mid-stream aborts the frame immediately; no partial words appear after release.
- Edge detection: gen_rise = gen_finish & ~gen_q; disc_rise = disc_finish & ~disc_q; gen_q and disc_q are registered every cycle.
- States:
  - IDLE:
    - On gen_rise: latch all N_PIX pixels into the buffer, clear class_valid, go to WAIT_DISC.
    - If disc_rise occurs in the same cycle: also latch score, compute is_real, go to STREAM.
    - disc_rise alone in IDLE is ignored.
  - WAIT_DISC: on disc_rise, latch score, set is_real = ($signed(score) >= $signed(THRESH)), set class_valid=1, go to STREAM. Latency from gen_rise to the first m_valid is at least 2 cycles.
  - STREAM:
    - Entering STREAM: m_valid=1 on the next cycle, with idx=0.
    - m_data = buffer[idx]; word N_PIX is the score.
    - Beat transfers when m_valid & m_ready; then idx increments.
    - m_valid remains high while m_ready is low. m_data and m_idx are held stable under backpressure; they must not change until the transfer.
    - Transfer with idx == N_PIX (m_last=1): go to DONE.
  - DONE: one cycle with m_valid=0 and busy=1, then IDLE. class_valid and is_real hold.
- One beat per cycle maximum; with m_ready held high, 10 beats take 10 consecutive cycles.
- A gen_rise in WAIT_DISC, STREAM or DONE sets overrun and is otherwise ignored; buffered data is not overwritten. overrun clears only on rst.
- Signed compare uses the full WIDTH; no truncation. THRESH is sign-extended to WIDTH.
- Levels that are already high at reset release produce a rise on the first cycle after release, because gen_q and disc_q reset to 0.

Test Plan:
- Basic frame: pixels = 1..9 (word k = k+1), score = 5; gen_finish rises at cycle 10, disc_finish at cycle 20, m_ready = 1 → beats idx 0..9 with data 1..9, 5; m_last only on idx 9; is_real = 1; class_valid = 1; busy returns to 0 two cycles after the last beat.
- Negative score: score = 32'hFFFF_FFFE (-2), THRESH = 0 → is_real = 0, class_valid = 1.
- Backpressure: m_ready toggles 1,0,0,1 repeatedly → every word appears exactly once, in order; m_data and m_idx are stable during ready-low cycles; m_valid never drops mid-frame.
- Simultaneous rise: gen_finish and disc_finish rise in the same cycle → skip WAIT_DISC; first m_valid at the second following edge; all 10 words are correct.
- Overrun: a second gen_finish pulse (low then high) during STREAM → overrun = 1; streamed pixels remain those of the first frame.
- Async reset mid-stream: assert rst between clock edges after beat 4 → m_valid, busy, class_valid and overrun drop to 0 immediately; the next frame after release streams from idx 0.
